// File: rtl/dec_2_4_seq.sv
// Sequenced 2-to-4 decoder: latches a code on valid/ready, drives d one-hot for HOLD_CYCLES, then GAP_CYCLES of zero. Optional parity check under DEC_PARITY_EN.
// Latency: d is one-hot the cycle after the accept; one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
// Backpressure: in_ready is low outside IDLE and while rst is high; in_valid is ignored while busy.
module dec_2_4_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       a,
`ifdef DEC_PARITY_EN
  input  logic             a_par,
  output logic             par_err,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       d,
  output logic             d_valid,
  output logic [CNT_W-1:0] dec_count,
  output logic             busy
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = (HW > GW) ? ((HW > 1) ? HW : 1) : ((GW > 1) ? GW : 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       d_q, d_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_q, drop_d;
  logic             par_ok;
  logic             accept;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
  logic perr_q;

  assign par_ok = (a_par == ^a);

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= accept && !par_ok;
    end
  end

  assign par_err = perr_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    vld_d   = vld_q;
    count_d = count_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          // A code with bad parity still consumes a full slot but drives nothing.
          d_d     = par_ok ? (4'b0001 << a) : 4'b0000;
          vld_d   = par_ok;
          drop_d  = !par_ok;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          d_d    = 4'b0000;
          vld_d  = 1'b0;
          drop_d = 1'b0;
          if (!drop_q) begin
            count_d = count_q + CNT_W'(1);
          end
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= 4'b0000;
      vld_q   <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign d         = d_q;
  assign d_valid   = vld_q;
  assign dec_count = count_q;
  assign busy      = (state_q != IDLE);

endmodule
